// File: rtl/aes_out_collector_pkg.sv
// Shared AES datapath types (sysdef view) and the collector's output-register state encoding.
package aes_out_collector_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int OUT_ENTRY_W = AES_BLOCK_W + 1;

    typedef struct packed {
        logic [AES_BLOCK_W-1:0] data;
        logic                   en_de;
        logic                   valid;
    } out_packet_t;

    typedef struct packed {
        logic [AES_BLOCK_W-1:0] data;
        logic [AES_BLOCK_W-1:0] key;
        logic                   en_de;
        logic                   set_key;
        logic                   valid;
    } in_packet_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/aes_out_ram.sv
// Circular result store of DEPTH-1 entries {en_de, data}; head entry is readable in the same cycle.
module aes_out_ram
    import aes_out_collector_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_clr,
    input  logic                   i_wr_en,
    input  logic [OUT_ENTRY_W-1:0] i_wr_data,
    input  logic                   i_rd_en,
    output logic [OUT_ENTRY_W-1:0] o_rd_data
);

    localparam int ENTRIES = DEPTH - 1;
    localparam int PTR_W   = $clog2(DEPTH);

    logic [OUT_ENTRY_W-1:0] r_mem [ENTRIES];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    // Data array carries no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/aes_out_collector.sv
// AES result collector: lossless capture, in-order valid/ready delivery, in-flight credit gating.
// Define AES_OUT_STATS_EN to build the delivered encrypt/decrypt counters.
module aes_out_collector
    import aes_out_collector_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  out_packet_t                eng_out,
    input  logic                       issue,
    input  logic                       issue_expect,
    output logic                       issue_ok,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [AES_BLOCK_W-1:0]     m_data,
    output logic                       m_en_de,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)+1:0]   inflight,
    output logic                       overflow,
    output logic [CNT_W-1:0]           enc_cnt,
    output logic [CNT_W-1:0]           dec_cnt
);

    localparam int CNT_BITS = $clog2(DEPTH) + 1;
    localparam int INF_BITS = $clog2(DEPTH) + 2;

    out_state_t             r_state;
    logic [AES_BLOCK_W-1:0] r_data;
    logic                   r_en_de;
    logic [CNT_BITS-1:0]    r_count;
    logic [INF_BITS-1:0]    r_inflight;
    logic                   r_overflow;

    logic                   w_out_full, w_pop, w_arr_empty, w_full, w_accept;
    logic                   w_need_fill, w_fill_head, w_bypass, w_ram_wr, w_ram_rd, w_inc;
    logic [OUT_ENTRY_W-1:0] w_head;
    logic [INF_BITS:0]      w_credit_sum;

    assign w_out_full  = (r_state == ST_FULL);
    assign w_pop       = w_out_full & m_ready;
    // Array occupancy is the total count minus the output register.
    assign w_arr_empty = (r_count == CNT_BITS'(w_out_full));
    assign w_full      = (r_count == CNT_BITS'(DEPTH));
    assign w_accept    = eng_out.valid & (!w_full | w_pop);
    assign w_need_fill = !w_out_full | w_pop;
    assign w_fill_head = w_need_fill & !w_arr_empty;
    assign w_bypass    = w_need_fill & w_arr_empty & w_accept;
    assign w_ram_wr    = !flush & w_accept & !w_bypass;
    assign w_ram_rd    = !flush & w_fill_head;
    assign w_inc       = issue & issue_expect;

    aes_out_ram #(.DEPTH(DEPTH)) u_ram (
        .clk       (clk),
        .rstn      (rstn),
        .i_clr     (flush),
        .i_wr_en   (w_ram_wr),
        .i_wr_data ({eng_out.en_de, eng_out.data}),
        .i_rd_en   (w_ram_rd),
        .o_rd_data (w_head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_en_de <= 1'b0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_fill_head) begin
            r_state <= ST_FULL;
            r_data  <= w_head[AES_BLOCK_W-1:0];
            r_en_de <= w_head[AES_BLOCK_W];
        end else if (w_bypass) begin
            r_state <= ST_FULL;
            r_data  <= eng_out.data;
            r_en_de <= eng_out.en_de;
        end else if (w_pop) begin
            r_state <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (eng_out.valid & w_full & !w_pop)
                r_overflow <= 1'b1;
        end
    end

    // Credit tracking ignores flush: discarded arrivals still retire their credit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= '0;
        end else begin
            case ({w_inc, eng_out.valid})
                2'b10:   if (r_inflight != '1) r_inflight <= r_inflight + 1'b1;
                2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign w_credit_sum = {1'b0, r_inflight} + (INF_BITS+1)'(r_count);
    assign issue_ok     = (w_credit_sum < (INF_BITS+1)'(DEPTH));

`ifdef AES_OUT_STATS_EN
    logic [CNT_W-1:0] r_enc_cnt;
    logic [CNT_W-1:0] r_dec_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_enc_cnt <= '0;
            r_dec_cnt <= '0;
        end else if (w_pop & !flush) begin
            if (r_en_de) r_enc_cnt <= r_enc_cnt + 1'b1;
            else         r_dec_cnt <= r_dec_cnt + 1'b1;
        end
    end

    assign enc_cnt = r_enc_cnt;
    assign dec_cnt = r_dec_cnt;
`else
    assign enc_cnt = '0;
    assign dec_cnt = '0;
`endif

    assign m_valid  = w_out_full;
    assign m_data   = r_data;
    assign m_en_de  = r_en_de;
    assign count    = r_count;
    assign inflight = r_inflight;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_aes_out_collector.sv
// Scoreboard bench for aes_out_collector: stimulus pushes expected results, a negedge monitor checks pops.
module tb_aes_out_collector;
    import aes_out_collector_pkg::*;

    localparam int DEPTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn;
    out_packet_t      eng_out;
    logic             issue, issue_expect, issue_ok;
    logic             m_valid, m_ready;
    logic [127:0]     m_data;
    logic             m_en_de, flush;
    logic [5:0]       count;
    logic [6:0]       inflight;
    logic             overflow;
    logic [CNT_W-1:0] enc_cnt, dec_cnt;

    aes_out_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .eng_out      (eng_out),
        .issue        (issue),
        .issue_expect (issue_expect),
        .issue_ok     (issue_ok),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_en_de      (m_en_de),
        .flush        (flush),
        .count        (count),
        .inflight     (inflight),
        .overflow     (overflow),
        .enc_cnt      (enc_cnt),
        .dec_cnt      (dec_cnt)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [128:0] exp_q[$];
    logic [128:0] mon_e;
    int           mcnt = 0;
    bit           movf = 1'b0;
    logic [CNT_W-1:0] enc0, dec0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && flush !== 1'b1) begin
            chk("count_le_depth", 128'(count > 6'd32), 128'd0);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0h expected none", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", m_data, mon_e[127:0]);
                    chk("out_en_de", 128'(m_en_de), 128'(mon_e[128]));
                    $display("pop data=%h en_de=%0b", m_data, m_en_de);
                end
            end
        end
    end

    // One clock cycle of stimulus; the occupancy model decides acceptance and drops.
    task automatic cyc(input bit arr, input logic [127:0] d, input bit ed, input bit rdy,
                       input bit iss, input bit expct, input bit fl);
        bit pop, acc;
        eng_out.data  = d;
        eng_out.en_de = ed;
        eng_out.valid = arr;
        m_ready       = rdy;
        issue         = iss;
        issue_expect  = expct;
        flush         = fl;
        pop = (mcnt > 0) && rdy;
        if (fl) begin
            exp_q.delete();
            mcnt = 0;
            movf = 1'b0;
        end else begin
            acc = arr && (mcnt < DEPTH || pop);
            if (acc) exp_q.push_back({ed, d});
            if (arr && !acc) movf = 1'b1;
            mcnt = mcnt + int'(acc) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && mcnt > 0; k++)
            cyc(1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({name, "_count_drained"}, 128'(count), 128'd0);
        chk({name, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
        chk({name, "_m_valid_low"}, 128'(m_valid), 128'd0);
    endtask

    initial begin
        rstn = 1'b0;
        eng_out = '0;
        issue = 1'b0; issue_expect = 1'b0; m_ready = 1'b0; flush = 1'b0;
        #12;
        chk("rst_m_valid", 128'(m_valid), 128'd0);
        chk("rst_m_data", m_data, 128'd0);
        chk("rst_m_en_de", 128'(m_en_de), 128'd0);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_inflight", 128'(inflight), 128'd0);
        chk("rst_overflow", 128'(overflow), 128'd0);
        chk("rst_issue_ok", 128'(issue_ok), 128'd1);
        chk("rst_enc_cnt", 128'(enc_cnt), 128'd0);
        chk("rst_dec_cnt", 128'(dec_cnt), 128'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single result
        cyc(1'b0, 128'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("single_inflight_1", 128'(inflight), 128'd1);
        cyc(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_m_valid", 128'(m_valid), 128'd1);
        chk("single_m_data", m_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("single_m_en_de", 128'(m_en_de), 128'd1);
        cyc(1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_m_valid_after", 128'(m_valid), 128'd0);
        chk("single_count_after", 128'(count), 128'd0);
        chk("single_inflight_after", 128'(inflight), 128'd0);

        // Key load: no result expected
        cyc(1'b0, 128'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("keyload_inflight", 128'(inflight), 128'd0);

        // Credit limit
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            if (i == 30) chk("credit_ok_after_31", 128'(issue_ok), 128'd1);
        end
        chk("credit_inflight_32", 128'(inflight), 128'd32);
        chk("credit_ok_low", 128'(issue_ok), 128'd0);
        cyc(1'b1, 128'hC0DE0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("credit_count_1", 128'(count), 128'd1);
        chk("credit_inflight_31", 128'(inflight), 128'd31);
        chk("credit_ok_still_low", 128'(issue_ok), 128'd0);
        cyc(1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("credit_ok_restored", 128'(issue_ok), 128'd1);
        for (int i = 0; i < 31; i++)
            cyc(1'b1, 128'hC0DE0100 + 128'(i), i[0], 1'b1, 1'b0, 1'b0, 1'b0);
        chk("credit_inflight_0", 128'(inflight), 128'd0);
        drain("credit");

        // Overflow
        for (int i = 0; i < 33; i++)
            cyc(1'b1, {96'h0F0F0F0F_11112222_33334444, 32'(i)}, i[0], 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_count_32", 128'(count), 128'd32);
        chk("ovf_flag", 128'(overflow), 128'd1);
        chk("ovf_issue_ok_low", 128'(issue_ok), 128'd0);
        drain("ovf");
        chk("ovf_sticky", 128'(overflow), 128'd1);

        // Back-to-back with m_ready toggling
        for (int i = 0; i < 100; i++)
            cyc(1'b1, {96'hB2B0B2B0_55AA55AA_DEADBEEF, 32'(i)}, (i % 3) == 0, i[0] == 1'b0,
                1'b0, 1'b0, 1'b0);
        chk("b2b_count_model", 128'(count), 128'(mcnt));
        chk("b2b_overflow_model", 128'(overflow), 128'(movf));
        drain("b2b");

        // Flush with 5 stored, inflight 3, arrival in the flush cycle
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 128'hF1F10000 + 128'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_pre_count", 128'(count), 128'd5);
        chk("flush_pre_inflight", 128'(inflight), 128'd3);
        cyc(1'b1, 128'hF1F1FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_m_valid", 128'(m_valid), 128'd0);
        chk("flush_inflight", 128'(inflight), 128'd2);
        chk("flush_overflow_clr", 128'(overflow), 128'd0);
        cyc(1'b1, 128'hF2F20001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'hF2F20002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_inflight_0", 128'(inflight), 128'd0);
        drain("flush");

        // Statistics: 3 encrypt and 2 decrypt pops
        enc0 = enc_cnt;
        dec0 = dec_cnt;
        cyc(1'b1, 128'h5A5A0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'h5A5A0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'h5A5A0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'h5A5A0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'h5A5A0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("stats");
`ifdef AES_OUT_STATS_EN
        chk("stats_enc_delta", 128'(enc_cnt - enc0), 128'd3);
        chk("stats_dec_delta", 128'(dec_cnt - dec0), 128'd2);
`else
        chk("stats_enc_tied", 128'(enc_cnt), 128'd0);
        chk("stats_dec_tied", 128'(dec_cnt), 128'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
